fpcvt_pipe: RTL



---
 rtl/fpcvt_pipe_if.sv | 35 +++
 rtl/fpcvt_pipe.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fpcvt_pipe_if.sv
// fpcvt_pipe_if: stream bundle for the pipelined linear-to-float converter.
//
// Groups the input-side valid/ready/data handshake and the output-side
// valid/ready handshake together with the encoded result fields
// (sign, exponent, significand, saturation flag).
//
// Modports:
//   slave  - the converter: takes in_valid/in_data/out_ready, drives
//            in_ready and all out_* signals.
//   master - the environment: sample source plus result consumer.
interface fpcvt_pipe_if #(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int SIG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [EXP_W-1:0] out_exp;
  logic [SIG_W-1:0] out_sig;
  logic             out_sat;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_sig, out_sat
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_sig, out_sat
  );
endinterface

// File: rtl/fpcvt_pipe.sv
// fpcvt_pipe: three-stage pipelined two's-complement to small-float converter.
//
// Encoded value = (-1)^out_sign * out_sig * 2^out_exp.
//   S1 splits the sample into sign and magnitude (most-negative input clamps).
//   S2 normalises: keeps the SIG_W bits below and including the leading one.
//   S3 rounds half up on the first dropped bit and clamps on exponent overflow.
// All stages advance together whenever the output is empty or being taken.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   strm   - fpcvt_pipe_if.slave: in_valid/in_ready/in_data,
//            out_valid/out_ready/out_sign/out_exp/out_sig/out_sat
//
// Build option: define FPCVT_ROUND_EN to enable round-half-up in S3;
// without it S3 truncates and out_sat only flags the most-negative input.
module fpcvt_pipe #(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int SIG_W = 4
) (
  input logic         clk,
  input logic         rst_n,
  fpcvt_pipe_if.slave strm
);
  localparam int MAG_W = IN_W - 1;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [SIG_W-1:0] SIG_MAX = '1;
  localparam logic [SIG_W-1:0] SIG_HALF = {1'b1, {(SIG_W-1){1'b0}}};
  localparam logic signed [IN_W-1:0] MOST_NEG = {1'b1, {MAG_W{1'b0}}};

  if (SIG_W < 2 || SIG_W >= IN_W - 1 || (IN_W - 1 - SIG_W) > (2**EXP_W - 1)) begin : g_param_check
    $error("fpcvt_pipe: illegal IN_W/EXP_W/SIG_W combination");
  end

  // Position of the most-significant set bit (0 when m is 0).
  function automatic int msb_index(input logic [MAG_W-1:0] m);
    int p;
    p = 0;
    for (int i = 0; i < MAG_W; i++) begin
      if ((m >> i) != '0) p = i;
    end
    return p;
  endfunction

`ifdef FPCVT_ROUND_EN
  // Round half up; a carry out renormalises to SIG_HALF with exp+1, and a
  // carry at the top exponent clamps to the largest code and flags it.
  function automatic logic [EXP_W+SIG_W:0] round_sat(
    input logic [EXP_W-1:0] e,
    input logic [SIG_W-1:0] s,
    input logic             r,
    input logic             sat_in
  );
    logic [SIG_W:0]   sum;
    logic [EXP_W-1:0] eo;
    logic [SIG_W-1:0] so;
    logic             st;
    sum = {1'b0, s} + {{SIG_W{1'b0}}, r};
    eo  = e;
    so  = sum[SIG_W-1:0];
    st  = sat_in;
    if (sum[SIG_W]) begin
      if (e == EXP_MAX) begin
        so = SIG_MAX;
        st = 1'b1;
      end else begin
        eo = e + 1'b1;
        so = SIG_HALF;
      end
    end
    return {st, eo, so};
  endfunction
`endif

  logic                   adv;
  logic                   vld_p0_q, vld_p1_q, out_valid_q;
  logic                   sign_p0_q, sat_p0_q;
  logic [MAG_W-1:0]       mag_p0_q;
  logic                   sign_p1_q, sat_p1_q;
  logic [EXP_W-1:0]       exp_p1_q;
  logic [SIG_W-1:0]       sig_p1_q;
  logic                   out_sign_q, out_sat_q;
  logic [EXP_W-1:0]       out_exp_q;
  logic [SIG_W-1:0]       out_sig_q;

  logic signed [IN_W-1:0] din_s;
  logic                   sign_p0_d, sat_p0_d;
  logic [MAG_W-1:0]       mag_p0_d;
  logic [EXP_W-1:0]       exp_p1_d;
  logic [SIG_W-1:0]       sig_p1_d;
  logic                   out_sat_d;
  logic [EXP_W-1:0]       out_exp_d;
  logic [SIG_W-1:0]       out_sig_d;
`ifdef FPCVT_ROUND_EN
  logic                   rbit_p1_d, rbit_p1_q;
`endif

  // Whole pipe moves as one; a full output that is not taken freezes everything.
  assign adv           = !out_valid_q || strm.out_ready;
  assign strm.in_ready = adv;
  assign din_s         = strm.in_data;

  // ---- S1: sign / magnitude -------------------------------------------------
  always_comb begin
    sign_p0_d = din_s[IN_W-1];
    sat_p0_d  = 1'b0;
    mag_p0_d  = din_s[MAG_W-1:0];
    if (din_s == MOST_NEG) begin
      // |min| does not fit in MAG_W bits.
      mag_p0_d = '1;
      sat_p0_d = 1'b1;
    end else if (sign_p0_d) begin
      mag_p0_d = MAG_W'(-din_s);
    end
  end

  // ---- S2: normalise --------------------------------------------------------
  always_comb begin : s2_norm
    int sh;
    sh       = msb_index(mag_p0_q) - SIG_W + 1;
    exp_p1_d = '0;
    sig_p1_d = mag_p0_q[SIG_W-1:0];
`ifdef FPCVT_ROUND_EN
    rbit_p1_d = 1'b0;
`endif
    if (mag_p0_q[MAG_W-1:SIG_W] != '0) begin
      exp_p1_d = EXP_W'(sh);
      sig_p1_d = SIG_W'(mag_p0_q >> sh);
`ifdef FPCVT_ROUND_EN
      rbit_p1_d = 1'(mag_p0_q >> (sh - 1));
`endif
    end
  end

  // ---- S3: round and clamp --------------------------------------------------
`ifdef FPCVT_ROUND_EN
  assign {out_sat_d, out_exp_d, out_sig_d} = round_sat(exp_p1_q, sig_p1_q, rbit_p1_q, sat_p1_q);
`else
  assign {out_sat_d, out_exp_d, out_sig_d} = {sat_p1_q, exp_p1_q, sig_p1_q};
`endif

  // Control plus the visible result: cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_sat_q   <= 1'b0;
      out_exp_q   <= '0;
      out_sig_q   <= '0;
    end else if (adv) begin
      vld_p0_q    <= strm.in_valid;
      vld_p1_q    <= vld_p0_q;
      out_valid_q <= vld_p1_q;
      if (vld_p1_q) begin
        out_sign_q <= sign_p1_q;
        out_sat_q  <= out_sat_d;
        out_exp_q  <= out_exp_d;
        out_sig_q  <= out_sig_d;
      end
    end
  end

  // Internal datapath: qualified by the stage valid, no reset needed.
  always_ff @(posedge clk) begin
    if (adv && strm.in_valid) begin
      sign_p0_q <= sign_p0_d;
      sat_p0_q  <= sat_p0_d;
      mag_p0_q  <= mag_p0_d;
    end
    if (adv && vld_p0_q) begin
      sign_p1_q <= sign_p0_q;
      sat_p1_q  <= sat_p0_q;
      exp_p1_q  <= exp_p1_d;
      sig_p1_q  <= sig_p1_d;
`ifdef FPCVT_ROUND_EN
      rbit_p1_q <= rbit_p1_d;
`endif
    end
  end

  assign strm.out_valid = out_valid_q;
  assign strm.out_sign  = out_sign_q;
  assign strm.out_sat   = out_sat_q;
  assign strm.out_exp   = out_exp_q;
  assign strm.out_sig   = out_sig_q;
endmodule
